// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Instruction-fetch stage: PC, IF/ID register, stall, redirect/flush, halt (optional via FETCH_HALT_EN)
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic [31:0]          pc,
    input  logic [31:0]          ir_in,
    output logic                 ifid_valid,
    output logic [31:0]          ifid_ir,
    output logic [31:0]          ifid_pc,
    output logic [31:0]          ifid_pc4,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] fetch_count
);

`ifdef FETCH_HALT_EN
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1
    } state_t;
`endif

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_pc;
    logic [31:0]          w_pc_nxt;
    logic                 r_ifid_valid;
    logic                 w_ifid_valid_nxt;
    logic [31:0]          r_ifid_ir;
    logic [31:0]          w_ifid_ir_nxt;
    logic [31:0]          r_ifid_pc;
    logic [31:0]          w_ifid_pc_nxt;
    logic [31:0]          r_ifid_pc4;
    logic [31:0]          w_ifid_pc4_nxt;
    logic [CNT_WIDTH-1:0] r_fetch_count;
    logic [CNT_WIDTH-1:0] w_fetch_count_nxt;

    // Low two bits of the redirect target are discarded: fetch is always word aligned.
    logic [31:0] w_redirect_target;
    logic [1:0]  w_unused_redirect_lsbs;
    logic [31:0] w_pc_plus4;
    logic        w_cnt_full;

    assign w_redirect_target      = {redirect_pc[31:2], 2'b00};
    assign w_unused_redirect_lsbs = redirect_pc[1:0];
    assign w_pc_plus4             = r_pc + 32'd4;
    assign w_cnt_full             = &r_fetch_count;

`ifdef FETCH_HALT_EN
    logic r_halted;
    logic w_halted_nxt;
    logic w_halt_word;

    assign w_halt_word = (ir_in == 32'h0000_0000);
`endif

    // State and datapath registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_ifid_valid  <= 1'b0;
            r_ifid_ir     <= 32'h0;
            r_ifid_pc     <= 32'h0;
            r_ifid_pc4    <= 32'h0;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_ifid_valid  <= w_ifid_valid_nxt;
            r_ifid_ir     <= w_ifid_ir_nxt;
            r_ifid_pc     <= w_ifid_pc_nxt;
            r_ifid_pc4    <= w_ifid_pc4_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

`ifdef FETCH_HALT_EN
    // Halt flag register, only present when the zero word stops fetch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_halted <= 1'b0;
        end else begin
            r_halted <= w_halted_nxt;
        end
    end
`endif

    // Next-state and datapath decode: redirect beats stall beats halt-detect beats a normal fetch.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_ifid_valid_nxt  = r_ifid_valid;
        w_ifid_ir_nxt     = r_ifid_ir;
        w_ifid_pc_nxt     = r_ifid_pc;
        w_ifid_pc4_nxt    = r_ifid_pc4;
        w_fetch_count_nxt = r_fetch_count;
`ifdef FETCH_HALT_EN
        w_halted_nxt      = r_halted;
`endif
        case (r_state)
            // Give memory a full cycle after reset before the first capture.
            S_BOOT: begin
                w_state_nxt = S_RUN;
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_target;
                end
            end
            S_RUN: begin
                if (redirect_valid) begin
                    w_pc_nxt         = w_redirect_target;
                    w_ifid_valid_nxt = 1'b0;
                end else if (stall) begin
                    w_pc_nxt = r_pc;
`ifdef FETCH_HALT_EN
                end else if (w_halt_word) begin
                    // PC stays on the halt word so a debugger sees where fetch stopped.
                    w_ifid_valid_nxt = 1'b0;
                    w_halted_nxt     = 1'b1;
                    w_state_nxt      = S_HALT;
`endif
                end else begin
                    w_ifid_ir_nxt    = ir_in;
                    w_ifid_pc_nxt    = r_pc;
                    w_ifid_pc4_nxt   = w_pc_plus4;
                    w_ifid_valid_nxt = 1'b1;
                    w_pc_nxt         = w_pc_plus4;
                    if (!w_cnt_full) begin
                        w_fetch_count_nxt = r_fetch_count + 1'b1;
                    end
                end
            end
`ifdef FETCH_HALT_EN
            // Stall is irrelevant here; only a redirect (or reset) restarts fetch.
            S_HALT: begin
                w_ifid_valid_nxt = 1'b0;
                if (redirect_valid) begin
                    w_pc_nxt     = w_redirect_target;
                    w_halted_nxt = 1'b0;
                    w_state_nxt  = S_RUN;
                end
            end
`endif
            default: begin
                w_state_nxt      = S_BOOT;
                w_ifid_valid_nxt = 1'b0;
            end
        endcase
    end

    assign pc          = r_pc;
    assign ifid_valid  = r_ifid_valid;
    assign ifid_ir     = r_ifid_ir;
    assign ifid_pc     = r_ifid_pc;
    assign ifid_pc4    = r_ifid_pc4;
    assign fetch_count = r_fetch_count;
`ifdef FETCH_HALT_EN
    assign halted      = r_halted;
`else
    assign halted      = 1'b0;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that sits directly upstream of the 16-word instruction memory. It owns the program counter and drives the byte address into the memory. It captures the returned instruction word into the IF/ID pipeline register for the decoder. It also handles pipeline stall, branch/jump redirect with flush, and the end-of-program halt.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- CNT_WIDTH, 16, width of the fetched-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- stall  in  1  hazard unit hold request; PC and IF/ID hold.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  target byte address; bits [1:0] ignored, forced to 0.
- pc  out  32  current fetch address, drives memory pc input (word index = pc[5:2]).
- ir_in  in  32  instruction word returned combinationally by memory for pc.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_ir  out  32  latched instruction.
- ifid_pc  out  32  address of latched instruction.
- ifid_pc4  out  32  ifid_pc + 4.
- halted  out  1  fetch stopped on halt word.
- fetch_count  out  CNT_WIDTH  instructions delivered to IF/ID, saturating.

## Operation
- States: BOOT, RUN, HALT. Reset (reset==0 at posedge) enters BOOT.
- BOOT: one cycle, no capture; gives memory one full cycle after reset release. Always proceeds to RUN; a redirect in BOOT is applied (pc <= target) and state goes to RUN.
- RUN, priority redirect > stall > halt-detect > normal:
  - redirect_valid: pc <= {redirect_pc[31:2],2'b00}; ifid_valid <= 0 (flush); other IF/ID fields hold; count unchanged.
  - stall (no redirect): pc, all IF/ID outputs, count hold.
  - normal: ifid_ir <= ir_in, ifid_pc <= pc, ifid_pc4 <= pc+4, ifid_valid <= 1, pc <= pc+4, fetch_count += 1 (saturates at all-ones).
- PC arithmetic: 32-bit, modulo 2^32; no range check. pc=0x3C advances to 0x40, which the memory aliases to word 0.
- HALT: pc holds at the halt-word address, ifid_valid=0, halted=1. Stall is ignored. Only redirect_valid (-> RUN, pc <= target, halted <= 0) or reset exits.
- Zero-word behaviour depends on the configuration macro.

## Timing
- Reset values: pc=RESET_PC, ifid_valid=0, ifid_ir=0, ifid_pc=0, ifid_pc4=0, halted=0, fetch_count=0, state=BOOT.
- Latency: instruction at address A appears on ifid_ir one posedge after pc==A with no stall/redirect.
- First valid IF/ID: 2nd posedge after reset release (BOOT then RUN capture).
- Redirect: target appears on pc after 1 posedge. The target instruction is valid in IF/ID after 2 posedges, with exactly one bubble.
- Stall and redirect in the same cycle: redirect wins, IF/ID flushed.
- Reset asserted mid-operation (any state, any stall/redirect): reset values at that posedge, overriding all.
- Memory writes on the opposite edge; ir_in is sampled only at posedge and must be stable by then.

## Configuration
- FETCH_HALT_EN defined: in RUN without stall/redirect, ir_in == 32'h0 is the halt word. At that posedge, ifid_valid <= 0, pc holds, count unchanged, halted <= 1, state -> HALT.
- FETCH_HALT_EN undefined: HALT state and halted logic are removed, and halted is tied to 0. A zero word is captured like any instruction, and PC keeps advancing and aliasing.

## Test plan
- Reset then run, memory words 0..2 nonzero, word 3 = 0: ifid_pc sequence 0x0, 0x4, 0x8 with ifid_valid=1 from 2nd posedge; with FETCH_HALT_EN, halted=1 and pc=0xC held, fetch_count=3.
- Stall held 3 cycles at pc=0x4: pc, ifid_ir, ifid_pc, fetch_count unchanged for 3 cycles. Next posedge resumes at 0x4 capture.
- Redirect to 0x23 while pc=0x8: pc=0x20 next cycle, ifid_valid=0 for one cycle, then ifid_pc=0x20.
- Stall and redirect_valid together targeting 0x0: redirect wins, pc=0x0, ifid_valid=0, no stall hold.
- In HALT, assert redirect to 0x4: halted=0, state RUN, ifid_pc=0x4 valid two posedges later. Then reset low mid-run: all outputs at reset values next posedge.
- Without FETCH_HALT_EN, run 17 fetches from 0: pc reaches 0x44, ifid_ir for pc 0x40 equals word 0, halted stays 0, fetch_count=17.
